// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: ALU operation codes, alu_op classes, funct7 patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_core_pkg;

   // 4-bit operation code driven into the ALU
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_ctrl_t;

   // Instruction class codes from the main controller
   localparam logic [1:0] ALU_OP_MEM    = 2'b00;  // load/store/auipc/jal/jalr
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;  // selects SUB / SRA

   localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Decodes alu_op/funct3/funct7 into the ALU operation code and flags undefined combinations.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module alu_ctrl_decoder
   import rv_core_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_ctrl,
   output logic       illegal_op
);

   alu_ctrl_t op_code;
   logic      f7_base;
   logic      f7_alt;

   assign f7_base  = (funct7 == FUNCT7_BASE);
   assign f7_alt   = (funct7 == FUNCT7_ALT);
   assign alu_ctrl = op_code;

   // Class/funct decode; undefined combinations fall back to ADD and raise illegal_op
   always_comb begin
      op_code    = ALU_ADD;
      illegal_op = 1'b0;
      case (alu_op)
         ALU_OP_MEM: begin
            op_code = ALU_ADD;
         end
         ALU_OP_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: op_code = ALU_SUB;
               3'b100, 3'b101: op_code = ALU_SLT;
               3'b110, 3'b111: op_code = ALU_SLTU;
               default: begin
                  op_code    = ALU_ADD;
                  illegal_op = 1'b1;
               end
            endcase
         end
         ALU_OP_RTYPE, ALU_OP_ITYPE: begin
            case (funct3)
               3'b000: begin
                  // I-type has no SUBI: its funct7 field is immediate bits
                  if (alu_op == ALU_OP_ITYPE || f7_base) begin
                     op_code = ALU_ADD;
                  end else if (f7_alt) begin
                     op_code = ALU_SUB;
                  end else begin
                     op_code    = ALU_ADD;
                     illegal_op = 1'b1;
                  end
               end
               3'b101: begin
                  if (f7_base) begin
                     op_code = ALU_SRL;
                  end else if (f7_alt) begin
                     op_code = ALU_SRA;
                  end else begin
                     op_code    = ALU_ADD;
                     illegal_op = 1'b1;
                  end
               end
               default: begin
                  case (funct3)
                     3'b001:  op_code = ALU_SLL;
                     3'b010:  op_code = ALU_SLT;
                     3'b011:  op_code = ALU_SLTU;
                     3'b100:  op_code = ALU_XOR;
                     3'b110:  op_code = ALU_OR;
                     default: op_code = ALU_AND;
                  endcase
                  // R-type needs a zero funct7 everywhere; I-type only on the shift-left form
                  if (alu_op == ALU_OP_RTYPE || funct3 == 3'b001) begin
                     illegal_op = !f7_base;
                  end
               end
            endcase
         end
         default: begin
            op_code    = ALU_ADD;
            illegal_op = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pc_adders_alu_ctrl.sv
// PC+step and PC+imm adders plus ALU-control decode, with a sticky illegal-op flag.
// Latency: datapath outputs combinational; illegal_seen updates on the clk edge after illegal_op.
// Backpressure: none; single-cycle core, outputs follow inputs every cycle.
module pc_adders_alu_ctrl
   import rv_core_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int PC_STEP = PC_STEP_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [1:0]       alu_op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic [3:0]       alu_ctrl,
   output logic             illegal_op,
   output logic             illegal_seen
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

   // Both sums wrap modulo 2^WIDTH; carry-out is dropped
   assign pc_plus4      = pc + STEP;
   assign branch_target = pc + imm;

   alu_ctrl_decoder u_dec (
      .alu_op     (alu_op),
      .funct3     (funct3),
      .funct7     (funct7),
      .alu_ctrl   (alu_ctrl),
      .illegal_op (illegal_op)
   );

   // Sticky record of any illegal decode; only reset clears it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_seen <= 1'b0;
      end else if (illegal_op) begin
         illegal_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_adders_alu_ctrl.sv
module tb_pc_adders_alu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [3:0]  alu_ctrl;
   logic        illegal_op;
   logic        illegal_seen;

   typedef struct {
      logic [31:0] p4;
      logic [31:0] bt;
      logic [3:0]  ctrl;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   pc_adders_alu_ctrl #(.WIDTH(32), .PC_STEP(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .imm           (imm),
      .alu_op        (alu_op),
      .funct3        (funct3),
      .funct7        (funct7),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .alu_ctrl      (alu_ctrl),
      .illegal_op    (illegal_op),
      .illegal_seen  (illegal_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Drive one input vector away from the rising edge, queue its expected outputs
   task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic [1:0] op,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] e_p4, input logic [31:0] e_bt,
                        input logic [3:0] e_ctrl, input logic e_ill);
      exp_t e;
      @(negedge clk);
      pc = p; imm = i; alu_op = op; funct3 = f3; funct7 = f7;
      e.p4 = e_p4; e.bt = e_bt; e.ctrl = e_ctrl; e.ill = e_ill;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against the settled outputs
   task automatic observe(input string tag);
      exp_t e;
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         $error("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".pc_plus4"},      pc_plus4,      e.p4);
         chk({tag, ".branch_target"}, branch_target, e.bt);
         chk({tag, ".alu_ctrl"},      {28'd0, alu_ctrl},   {28'd0, e.ctrl});
         chk({tag, ".illegal_op"},    {31'd0, illegal_op}, {31'd0, e.ill});
      end
   endtask

   initial begin
      reset = 1'b0;
      pc = '0; imm = '0; alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0000000;
      #2;
      chk("reset.illegal_seen", {31'd0, illegal_seen}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Adders plus legal decodes
      drive(32'h0000_0000, 32'h0000_0010, 2'b00, 3'b101, 7'b1111111, 32'h0000_0004, 32'h0000_0010, 4'b0010, 1'b0);
      observe("mem_arbitrary_funct");
      drive(32'hFFFF_FFFC, 32'h0000_0004, 2'b10, 3'b000, 7'b0000000, 32'h0000_0000, 32'h0000_0000, 4'b0010, 1'b0);
      observe("wrap_r_add");
      drive(32'h0000_0040, 32'hFFFF_FFF8, 2'b10, 3'b000, 7'b0100000, 32'h0000_0044, 32'h0000_0038, 4'b0110, 1'b0);
      observe("neg_imm_r_sub");
      drive(32'h0000_1000, 32'h0000_0000, 2'b10, 3'b101, 7'b0100000, 32'h0000_1004, 32'h0000_1000, 4'b1001, 1'b0);
      observe("r_sra");
      drive(32'h0000_1000, 32'h0000_0100, 2'b10, 3'b111, 7'b0000000, 32'h0000_1004, 32'h0000_1100, 4'b0000, 1'b0);
      observe("r_and");
      drive(32'h0000_2000, 32'h0000_0000, 2'b10, 3'b101, 7'b0000000, 32'h0000_2004, 32'h0000_2000, 4'b0101, 1'b0);
      observe("r_srl");
      drive(32'h0000_2000, 32'h0000_0000, 2'b10, 3'b100, 7'b0000000, 32'h0000_2004, 32'h0000_2000, 4'b0011, 1'b0);
      observe("r_xor");
      drive(32'h8000_0000, 32'h8000_0000, 2'b01, 3'b000, 7'b0000000, 32'h8000_0004, 32'h0000_0000, 4'b0110, 1'b0);
      observe("br_sub");
      drive(32'h8000_0000, 32'h0000_0000, 2'b01, 3'b100, 7'b1010101, 32'h8000_0004, 32'h8000_0000, 4'b0111, 1'b0);
      observe("br_slt");
      drive(32'h8000_0000, 32'h0000_0000, 2'b01, 3'b111, 7'b0000000, 32'h8000_0004, 32'h8000_0000, 4'b1000, 1'b0);
      observe("br_sltu");
      drive(32'h0000_0100, 32'hFFFF_FF00, 2'b11, 3'b000, 7'b0100000, 32'h0000_0104, 32'h0000_0000, 4'b0010, 1'b0);
      observe("i_add_no_subi");
      drive(32'h0000_0100, 32'h0000_0000, 2'b11, 3'b101, 7'b0100000, 32'h0000_0104, 32'h0000_0100, 4'b1001, 1'b0);
      observe("i_srai");
      drive(32'h0000_0100, 32'h0000_0000, 2'b11, 3'b110, 7'b1111111, 32'h0000_0104, 32'h0000_0100, 4'b0001, 1'b0);
      observe("i_ori_imm_bits");
      @(posedge clk); #1;
      chk("no_illegal_yet.illegal_seen", {31'd0, illegal_seen}, 32'd0);

      // Illegal decodes
      drive(32'h0000_0200, 32'h0000_0000, 2'b10, 3'b001, 7'b0100000, 32'h0000_0204, 32'h0000_0200, 4'b0100, 1'b1);
      observe("r_sll_bad_f7");
      drive(32'h0000_0200, 32'h0000_0000, 2'b01, 3'b010, 7'b0000000, 32'h0000_0204, 32'h0000_0200, 4'b0010, 1'b1);
      observe("br_undefined");
      drive(32'h0000_0200, 32'h0000_0000, 2'b11, 3'b101, 7'b0000001, 32'h0000_0204, 32'h0000_0200, 4'b0010, 1'b1);
      observe("i_shift_bad_f7");
      drive(32'h0000_0300, 32'h0000_0020, 2'b10, 3'b000, 7'b1111111, 32'h0000_0304, 32'h0000_0320, 4'b0010, 1'b1);
      observe("r_add_bad_f7");
      @(posedge clk); #1;
      chk("after_illegal.illegal_seen", {31'd0, illegal_seen}, 32'd1);

      // Legal input afterwards: flag holds
      drive(32'h0000_0400, 32'h0000_0040, 2'b10, 3'b110, 7'b0000000, 32'h0000_0404, 32'h0000_0440, 4'b0001, 1'b0);
      observe("r_or_after_illegal");
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("sticky_hold.illegal_seen", {31'd0, illegal_seen}, 32'd1);

      // Asynchronous reset between edges clears only the flag
      @(negedge clk);
      #2;
      reset = 1'b0;
      sb.push_back('{32'h0000_0404, 32'h0000_0440, 4'b0001, 1'b0});
      #1;
      chk("async_reset.illegal_seen", {31'd0, illegal_seen}, 32'd0);
      observe("during_reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("after_release.illegal_seen", {31'd0, illegal_seen}, 32'd0);
      chk("after_release.pc_plus4", pc_plus4, 32'h0000_0404);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
